// File: rtl/round_pkg.sv
`default_nettype none
// ============================================================================
// Module      : round_pkg
// Description : Shared types and constants for the round_pipe rounding
//               pipeline (rounding-mode enum, saturation counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package round_pkg;

    typedef enum logic [1:0] {
        TRUNC     = 2'd0,
        HALF_UP   = 2'd1,
        HALF_EVEN = 2'd2,
        CEIL      = 2'd3
    } round_mode_e;

    localparam int SAT_CNT_W = 16;

endpackage : round_pkg
`default_nettype wire

// File: rtl/round_core.sv
`default_nettype none
// ============================================================================
// Module      : round_core
// Description : Combinational rounding increment and saturation. Takes the
//               integer part q, guard bit g and sticky bit s of one beat and
//               produces the rounded magnitude plus a clamp flag.
// Revision    : 1.0 - initial release
// ============================================================================
module round_core
    import round_pkg::*;
#(
    parameter int OUT_W = 13
) (
    input  logic [OUT_W-1:0] q,
    input  logic             g,
    input  logic             s,
    input  round_mode_e      mode,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    logic w_inc;

    // Pick the rounding increment from the mode; q[0] breaks exact ties for HALF_EVEN.
    always_comb begin
        w_inc = 1'b0;
        case (mode)
            TRUNC:     w_inc = 1'b0;
            HALF_UP:   w_inc = g;
            HALF_EVEN: w_inc = g & (s | q[0]);
            CEIL:      w_inc = g | s;
            default:   w_inc = 1'b0;
        endcase
    end

    // Clamp to all ones when the increment would carry out of the output width.
    always_comb begin
        sat  = (&q) & w_inc;
        data = sat ? {OUT_W{1'b1}} : (q + OUT_W'(w_inc));
    end

endmodule : round_core
`default_nettype wire

// File: rtl/round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : round_pipe
// Description : Two-stage valid/ready pipeline that rounds an unsigned
//               fixed-point magnitude (IN_W bits, IN_W-OUT_W fraction bits)
//               to an OUT_W-bit integer using one of four rounding modes,
//               saturating at all ones.
//               Optional macro ROUND_PIPE_SAT_CNT_EN builds a 16-bit
//               saturating counter of delivered clamped results.
// Revision    : 1.0 - initial release
// ============================================================================
module round_pipe
    import round_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int OUT_W = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_sat,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_cnt
);

    localparam int FRAC_W = IN_W - OUT_W;

    if (FRAC_W < 1) begin : g_frac_w_check
        $error("round_pipe: IN_W must be greater than OUT_W");
    end

    // Sticky bit: OR of everything below the guard bit (none when only one fraction bit).
    logic w_in_s;
    if (FRAC_W >= 2) begin : g_sticky
        assign w_in_s = |in_data[FRAC_W-2:0];
    end else begin : g_no_sticky
        assign w_in_s = 1'b0;
    end

    // Stage 1: split fields and mode
    logic             r_s1_valid;
    logic [OUT_W-1:0] r_s1_q;
    logic             r_s1_g;
    logic             r_s1_s;
    round_mode_e      r_s1_mode;

    // Stage 2: rounded result
    logic             r_s2_valid;
    logic [OUT_W-1:0] r_s2_data;
    logic             r_s2_sat;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [OUT_W-1:0] w_core_data;
    logic             w_core_sat;

    // Each stage advances when it is empty or its successor frees up; in_ready
    // is therefore purely a function of registered valids and out_ready.
    assign w_s2_load = ~r_s2_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    // Capture the split beat into stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_q     <= '0;
            r_s1_g     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_mode  <= TRUNC;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_q    <= in_data[IN_W-1:FRAC_W];
                r_s1_g    <= in_data[FRAC_W-1];
                r_s1_s    <= w_in_s;
                r_s1_mode <= round_mode_e'(in_mode);
            end
        end
    end

    round_core #(
        .OUT_W (OUT_W)
    ) u_round_core (
        .q    (r_s1_q),
        .g    (r_s1_g),
        .s    (r_s1_s),
        .mode (r_s1_mode),
        .data (w_core_data),
        .sat  (w_core_sat)
    );

    // Register the rounded result; data only changes when a new beat arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_sat   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_core_data;
                r_s2_sat  <= w_core_sat;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_sat   = r_s2_sat;

`ifdef ROUND_PIPE_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] r_sat_cnt;

    // Count delivered clamped results, sticking at full scale; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_s2_valid && out_ready && r_s2_sat && (r_sat_cnt != {SAT_CNT_W{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    logic w_unused_sat_clr;
    assign w_unused_sat_clr = sat_clr;
    assign sat_cnt          = '0;
`endif

endmodule : round_pipe
`default_nettype wire

// File: doc/round_pipe.md
ROUND_PIPE -- requirements
Module: round_pipe

Interface
REQ-001 Parameter IN_W, 17, input magnitude width in bits.
REQ-002 Parameter OUT_W, 13, output magnitude width in bits. FRAC_W = IN_W-OUT_W SHALL be at least 1; otherwise elaboration SHALL fail.
REQ-003 clk  input  1  sole clock; all state rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input beat offered.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_data  input  IN_W  unsigned fixed-point magnitude, FRAC_W fraction bits.
REQ-008 in_mode  input  2  rounding mode, sampled with in_data: 0 TRUNC, 1 HALF_UP, 2 HALF_EVEN, 3 CEIL.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  OUT_W  rounded magnitude.
REQ-012 out_sat  output  1  result clamped, qualified by out_valid.
REQ-013 sat_clr  input  1  synchronous clear of the saturation counter.
REQ-014 sat_cnt  output  16  count of saturated results delivered.

Function
REQ-015 The block SHALL split each beat into q = in_data[IN_W-1:FRAC_W], guard g = in_data[FRAC_W-1], and sticky s = OR of in_data[FRAC_W-2:0], with s = 0 when FRAC_W = 1.
REQ-016 The increment SHALL be: TRUNC 0; HALF_UP g; HALF_EVEN g AND (s OR q[0]); CEIL g OR s.
REQ-017 If q is all ones and the increment is 1, out_data SHALL be all ones with out_sat = 1; otherwise out_data = q + increment with out_sat = 0.
REQ-018 The datapath SHALL be two register stages: stage 1 holds the split fields and mode; stage 2 holds the result and sat flag.
REQ-019 A beat transfers on a port when valid and ready are both high in the same cycle.
REQ-020 Latency SHALL be 2 cycles from input transfer to out_valid, with throughput of one beat per cycle while out_ready = 1.
REQ-021 Stage 2 SHALL load when it is empty or out_ready = 1; stage 1 SHALL load when it is empty or stage 2 loads.
REQ-022 in_ready SHALL equal the stage 1 load condition and SHALL NOT depend combinationally on in_valid.
REQ-023 While out_valid = 1 and out_ready = 0, out_data and out_sat SHALL hold stable.
REQ-024 Under a sustained stall, the block SHALL buffer exactly 2 beats before in_ready falls.
REQ-025 No beat SHALL be dropped or duplicated, and results SHALL leave in input order.
REQ-026 A change of in_mode SHALL affect only beats transferred with that mode.

Reset
REQ-027 On rst, all valids SHALL clear; out_valid, out_data, out_sat and sat_cnt SHALL reset to 0; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 rst asserted mid-stream SHALL discard all in-flight beats without producing output.

Configuration
REQ-029 The macro ROUND_PIPE_SAT_CNT_EN, when defined, SHALL enable the counter: sat_cnt increments on each output transfer with out_sat = 1 and holds at 16'hFFFF.
REQ-030 sat_clr SHALL take priority over a simultaneous increment and SHALL clear sat_cnt to 0.
REQ-031 When ROUND_PIPE_SAT_CNT_EN is undefined, sat_cnt SHALL be constant 0, sat_clr SHALL be ignored, and no counter flops SHALL be built.

Structure
REQ-032 Package round_pkg SHALL hold the round_mode_e enum (TRUNC, HALF_UP, HALF_EVEN, CEIL) and the SAT_CNT_W = 16 constant.
REQ-033 The combinational increment and saturation logic SHALL be sub-module round_core, instantiated between stage 1 and stage 2.

Verification (IN_W=17, OUT_W=13)
REQ-034 Rounding modes, out_ready held at 1:
  - 0x00028 HALF_UP -> 0x003; HALF_EVEN -> 0x002.
  - 0x00018 HALF_EVEN -> 0x002.
  - 0x00021 CEIL -> 0x003; TRUNC -> 0x002.
  - 0x00027 HALF_UP -> 0x002.
REQ-035 Saturation: 0x1FFF8 HALF_UP -> 0x1FFF with out_sat = 1; the same input in TRUNC -> 0x1FFF with out_sat = 0.
REQ-036 Backpressure: hold out_ready = 0 and offer 4 beats.
  - 2 beats are accepted, then in_ready = 0.
  - out_data is stable throughout the stall.
  - On release, the 4 results emerge in order with no gaps.
REQ-037 Reset mid-stream: assert rst with 2 beats in flight -> out_valid = 0 and sat_cnt = 0; the next beat appears 2 cycles after it is accepted.
REQ-038 Counter (macro defined):
  - 3 saturating beats -> sat_cnt = 3.
  - sat_clr in the same cycle as a 4th saturating beat -> sat_cnt = 0.
  - 65,540 saturating beats -> sat_cnt = 0xFFFF.
  - Macro undefined: sat_cnt stays 0.
